// File: rtl/id_ex_reg_pkg.sv
// rtl/id_ex_reg_pkg.sv - shared ALU op codes and ID/EX constants
package id_ex_reg_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int TNEW_W     = 2;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_LUI = 3'd7
  } alu_op_e;

endpackage

// File: rtl/id_ex_reg_fwd_mux.sv
// rtl/id_ex_reg_fwd_mux.sv - M/W bypass select for one E-stage operand
module id_ex_reg_fwd_mux
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  input  logic                  m_we,
  input  logic [REG_ADDR_W-1:0] m_wr_addr,
  input  logic [DATA_W-1:0]     m_wr_data,
  input  logic                  w_we,
  input  logic [REG_ADDR_W-1:0] w_wr_addr,
  input  logic [DATA_W-1:0]     w_wr_data,
  output logic [DATA_W-1:0]     fwd_data
);

  logic m_hit;
  logic w_hit;

  // $0 is hardwired, so a write to it must never shadow the read value
  always_comb begin
    m_hit = m_we && (m_wr_addr != '0) && (m_wr_addr == rd_addr);
    w_hit = w_we && (w_wr_addr != '0) && (w_wr_addr == rd_addr);
    fwd_data = rd_data;
    if (m_hit) begin
      fwd_data = m_wr_data;
    end else if (w_hit) begin
      fwd_data = w_wr_data;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - D->E pipeline register with bubble insertion and E-stage forwarding
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [31:0]           d_instr,
  input  logic [31:0]           d_pc,
  input  logic [DATA_W-1:0]     d_rs_data,
  input  logic [DATA_W-1:0]     d_rt_data,
  input  logic [DATA_W-1:0]     d_ext_imm,
  input  logic [REG_ADDR_W-1:0] d_rs_addr,
  input  logic [REG_ADDR_W-1:0] d_rt_addr,
  input  logic [REG_ADDR_W-1:0] d_wr_addr,
  input  logic [2:0]            d_alu_op,
  input  logic                  d_alu_src_imm,
  input  logic                  d_mem_we,
  input  logic                  d_mem_to_reg,
  input  logic [TNEW_W-1:0]     d_tnew,
  input  logic [REG_ADDR_W-1:0] m_wr_addr,
  input  logic [DATA_W-1:0]     m_wr_data,
  input  logic                  m_we,
  input  logic [REG_ADDR_W-1:0] w_wr_addr,
  input  logic [DATA_W-1:0]     w_wr_data,
  input  logic                  w_we,
  output logic [31:0]           e_instr,
  output logic [31:0]           e_pc,
  output logic [REG_ADDR_W-1:0] e_rs_addr,
  output logic [REG_ADDR_W-1:0] e_rt_addr,
  output logic [REG_ADDR_W-1:0] e_wr_addr,
  output logic [2:0]            e_alu_op,
  output logic [DATA_W-1:0]     e_src_a,
  output logic [DATA_W-1:0]     e_src_b,
  output logic [DATA_W-1:0]     e_store_data,
  output logic                  e_mem_we,
  output logic                  e_mem_to_reg,
  output logic [TNEW_W-1:0]     e_tnew
);

  logic [31:0]           instr_q, instr_d;
  logic [31:0]           pc_q, pc_d;
  logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [REG_ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [2:0]            alu_op_q, alu_op_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d;
  logic [DATA_W-1:0]     rt_data_q, rt_data_d;
  logic [DATA_W-1:0]     ext_imm_q, ext_imm_d;
  logic                  alu_src_imm_q, alu_src_imm_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [TNEW_W-1:0]     tnew_q, tnew_d;

  logic [DATA_W-1:0]     fwd_rs;
  logic [DATA_W-1:0]     fwd_rt;

  always_comb begin
    instr_d       = d_instr;
    pc_d          = d_pc;
    rs_addr_d     = d_rs_addr;
    rt_addr_d     = d_rt_addr;
    wr_addr_d     = d_wr_addr;
    alu_op_d      = d_alu_op;
    rs_data_d     = d_rs_data;
    rt_data_d     = d_rt_data;
    ext_imm_d     = d_ext_imm;
    alu_src_imm_d = d_alu_src_imm;
    mem_we_d      = d_mem_we;
    mem_to_reg_d  = d_mem_to_reg;
    tnew_d        = d_tnew;
    // Bubble keeps the PC so a later exception can still be attributed
    if (stall) begin
      instr_d       = NOP_INSTR;
      rs_addr_d     = '0;
      rt_addr_d     = '0;
      wr_addr_d     = '0;
      alu_op_d      = ALU_ADD;
      rs_data_d     = '0;
      rt_data_d     = '0;
      ext_imm_d     = '0;
      alu_src_imm_d = 1'b0;
      mem_we_d      = 1'b0;
      mem_to_reg_d  = 1'b0;
      tnew_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q       <= NOP_INSTR;
      pc_q          <= PC_RESET;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      wr_addr_q     <= '0;
      alu_op_q      <= ALU_ADD;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      ext_imm_q     <= '0;
      alu_src_imm_q <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      tnew_q        <= '0;
    end else begin
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      rs_addr_q     <= rs_addr_d;
      rt_addr_q     <= rt_addr_d;
      wr_addr_q     <= wr_addr_d;
      alu_op_q      <= alu_op_d;
      rs_data_q     <= rs_data_d;
      rt_data_q     <= rt_data_d;
      ext_imm_q     <= ext_imm_d;
      alu_src_imm_q <= alu_src_imm_d;
      mem_we_q      <= mem_we_d;
      mem_to_reg_q  <= mem_to_reg_d;
      tnew_q        <= tnew_d;
    end
  end

  id_ex_reg_fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs (
    .rd_addr   (rs_addr_q),
    .rd_data   (rs_data_q),
    .m_we      (m_we),
    .m_wr_addr (m_wr_addr),
    .m_wr_data (m_wr_data),
    .w_we      (w_we),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .fwd_data  (fwd_rs)
  );

  id_ex_reg_fwd_mux #(.DATA_W(DATA_W)) u_fwd_rt (
    .rd_addr   (rt_addr_q),
    .rd_data   (rt_data_q),
    .m_we      (m_we),
    .m_wr_addr (m_wr_addr),
    .m_wr_data (m_wr_data),
    .w_we      (w_we),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .fwd_data  (fwd_rt)
  );

  assign e_instr      = instr_q;
  assign e_pc         = pc_q;
  assign e_rs_addr    = rs_addr_q;
  assign e_rt_addr    = rt_addr_q;
  assign e_wr_addr    = wr_addr_q;
  assign e_alu_op     = alu_op_q;
  assign e_src_a      = fwd_rs;
  assign e_src_b      = alu_src_imm_q ? ext_imm_q : fwd_rt;
  assign e_store_data = fwd_rt;
  assign e_mem_we     = mem_we_q;
  assign e_mem_to_reg = mem_to_reg_q;
  assign e_tnew       = tnew_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - self-checking bench for id_ex_reg
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] d_instr, d_pc, d_rs_data, d_rt_data, d_ext_imm;
  logic [4:0]  d_rs_addr, d_rt_addr, d_wr_addr;
  logic [2:0]  d_alu_op;
  logic        d_alu_src_imm, d_mem_we, d_mem_to_reg;
  logic [1:0]  d_tnew;
  logic [4:0]  m_wr_addr, w_wr_addr;
  logic [31:0] m_wr_data, w_wr_data;
  logic        m_we, w_we;
  logic [31:0] e_instr, e_pc, e_src_a, e_src_b, e_store_data;
  logic [4:0]  e_rs_addr, e_rt_addr, e_wr_addr;
  logic [2:0]  e_alu_op;
  logic        e_mem_we, e_mem_to_reg;
  logic [1:0]  e_tnew;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .stall(stall),
    .d_instr(d_instr), .d_pc(d_pc), .d_rs_data(d_rs_data), .d_rt_data(d_rt_data),
    .d_ext_imm(d_ext_imm), .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_wr_addr(d_wr_addr), .d_alu_op(d_alu_op), .d_alu_src_imm(d_alu_src_imm),
    .d_mem_we(d_mem_we), .d_mem_to_reg(d_mem_to_reg), .d_tnew(d_tnew),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_we(m_we),
    .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .w_we(w_we),
    .e_instr(e_instr), .e_pc(e_pc), .e_rs_addr(e_rs_addr), .e_rt_addr(e_rt_addr),
    .e_wr_addr(e_wr_addr), .e_alu_op(e_alu_op), .e_src_a(e_src_a), .e_src_b(e_src_b),
    .e_store_data(e_store_data), .e_mem_we(e_mem_we), .e_mem_to_reg(e_mem_to_reg),
    .e_tnew(e_tnew)
  );

  typedef struct {
    logic [31:0] instr, pc, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, wr;
    logic [2:0]  op;
    logic        use_imm, mem_we, mem_to_reg;
    logic [1:0]  tnew;
  } e_rec_t;

  e_rec_t model;
  bit     model_valid = 1'b0;

  function automatic e_rec_t empty_rec(input logic [31:0] pc);
    e_rec_t r;
    r.instr = 32'h0; r.pc = pc; r.rs_data = 0; r.rt_data = 0; r.imm = 0;
    r.rs = 0; r.rt = 0; r.wr = 0; r.op = ALU_ADD;
    r.use_imm = 0; r.mem_we = 0; r.mem_to_reg = 0; r.tnew = 0;
    return r;
  endfunction

  // Youngest producer wins; $0 is never a real destination
  function automatic logic [31:0] bypass(input logic [4:0] idx, input logic [31:0] own);
    logic [4:0]  dst [2];
    logic [31:0] val [2];
    logic        vld [2];
    dst[0] = m_wr_addr; val[0] = m_wr_data; vld[0] = m_we;
    dst[1] = w_wr_addr; val[1] = w_wr_data; vld[1] = w_we;
    for (int k = 0; k < 2; k++)
      if (vld[k] && idx != 0 && dst[k] == idx) return val[k];
    return own;
  endfunction

  always @(posedge clk) begin
    e_rec_t n;
    if (reset) begin
      n = empty_rec(32'h0000_3000);
    end else if (stall) begin
      n = empty_rec(d_pc);
    end else begin
      n.instr = d_instr; n.pc = d_pc; n.rs_data = d_rs_data; n.rt_data = d_rt_data;
      n.imm = d_ext_imm; n.rs = d_rs_addr; n.rt = d_rt_addr; n.wr = d_wr_addr;
      n.op = d_alu_op; n.use_imm = d_alu_src_imm; n.mem_we = d_mem_we;
      n.mem_to_reg = d_mem_to_reg; n.tnew = d_tnew;
    end
    if (reset || model_valid) begin
      model <= n;
      model_valid <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      logic [31:0] a, b;
      a = bypass(model.rs, model.rs_data);
      b = bypass(model.rt, model.rt_data);
      chk("m_instr", e_instr, model.instr);
      chk("m_pc", e_pc, model.pc);
      chk("m_rs_addr", 32'(e_rs_addr), 32'(model.rs));
      chk("m_rt_addr", 32'(e_rt_addr), 32'(model.rt));
      chk("m_wr_addr", 32'(e_wr_addr), 32'(model.wr));
      chk("m_alu_op", 32'(e_alu_op), 32'(model.op));
      chk("m_src_a", e_src_a, a);
      chk("m_src_b", e_src_b, model.use_imm ? model.imm : b);
      chk("m_store_data", e_store_data, b);
      chk("m_mem_we", 32'(e_mem_we), 32'(model.mem_we));
      chk("m_mem_to_reg", 32'(e_mem_to_reg), 32'(model.mem_to_reg));
      chk("m_tnew", 32'(e_tnew), 32'(model.tnew));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1; stall = 0;
    d_instr = 32'hDEAD_BEEF; d_pc = 32'h0000_4000; d_rs_data = 32'h55; d_rt_data = 32'h66;
    d_ext_imm = 32'h77; d_rs_addr = 5'd8; d_rt_addr = 5'd9; d_wr_addr = 5'd10;
    d_alu_op = ALU_SUB; d_alu_src_imm = 1; d_mem_we = 1; d_mem_to_reg = 1; d_tnew = 2'd2;
    m_wr_addr = 0; m_wr_data = 0; m_we = 0; w_wr_addr = 0; w_wr_data = 0; w_we = 0;

    step();
    chk("rst_instr", e_instr, 32'h0);
    chk("rst_pc", e_pc, 32'h0000_3000);
    chk("rst_wr_addr", 32'(e_wr_addr), 32'h0);
    chk("rst_src_a", e_src_a, 32'h0);
    chk("rst_src_b", e_src_b, 32'h0);
    chk("rst_alu_op", 32'(e_alu_op), 32'(ALU_ADD));
    chk("rst_mem_we", 32'(e_mem_we), 32'h0);

    reset = 0;
    d_instr = 32'h3421_0005; d_pc = 32'h0000_3004; d_rs_addr = 5'd1; d_rt_addr = 5'd1;
    d_wr_addr = 5'd1; d_rs_data = 32'd7; d_rt_data = 32'd7; d_ext_imm = 32'd5;
    d_alu_src_imm = 1; d_alu_op = ALU_OR; d_mem_we = 0; d_mem_to_reg = 0; d_tnew = 2'd1;
    step();
    chk("ld_src_a", e_src_a, 32'd7);
    chk("ld_src_b", e_src_b, 32'd5);
    chk("ld_wr_addr", 32'(e_wr_addr), 32'd1);
    chk("ld_instr", e_instr, 32'h3421_0005);
    chk("ld_tnew", 32'(e_tnew), 32'd1);

    stall = 1; d_pc = 32'h0000_3010; d_wr_addr = 5'd4; d_mem_we = 1;
    d_instr = 32'hAC04_0000; d_alu_op = ALU_ADD;
    step();
    chk("bub_instr", e_instr, 32'h0);
    chk("bub_wr_addr", 32'(e_wr_addr), 32'h0);
    chk("bub_mem_we", 32'(e_mem_we), 32'h0);
    chk("bub_pc", e_pc, 32'h0000_3010);
    chk("bub_tnew", 32'(e_tnew), 32'h0);

    stall = 0;
    step();
    chk("rep_wr_addr", 32'(e_wr_addr), 32'd4);
    chk("rep_mem_we", 32'(e_mem_we), 32'd1);
    chk("rep_instr", e_instr, 32'hAC04_0000);

    d_instr = 32'h0064_2820; d_pc = 32'h0000_3014; d_rs_addr = 5'd3; d_rs_data = 32'h1111;
    d_rt_addr = 5'd0; d_rt_data = 32'h0; d_wr_addr = 5'd5; d_mem_we = 0;
    d_alu_src_imm = 0; d_ext_imm = 32'h0; d_tnew = 2'd1;
    step();
    m_we = 1; m_wr_addr = 5'd3; m_wr_data = 32'hAAAA;
    w_we = 1; w_wr_addr = 5'd3; w_wr_data = 32'hBBBB;
    #1 chk("fwd_m_prio", e_src_a, 32'hAAAA);
    m_we = 0;
    #1 chk("fwd_w", e_src_a, 32'hBBBB);
    w_we = 0;
    #1 chk("fwd_none", e_src_a, 32'h1111);

    m_we = 1; m_wr_addr = 5'd0; m_wr_data = 32'hFFFF_FFFF;
    w_we = 1; w_wr_addr = 5'd0; w_wr_data = 32'hFFFF_FFFF;
    step();
    chk("z0_store", e_store_data, 32'h0);
    chk("z0_src_b", e_src_b, 32'h0);
    chk("z0_src_a", e_src_a, 32'h1111);

    m_we = 0; w_we = 0;
    d_instr = 32'hAC42_0010; d_pc = 32'h0000_3018; d_rt_addr = 5'd2; d_rt_data = 32'h5555;
    d_alu_src_imm = 1; d_ext_imm = 32'h10; d_mem_we = 1; d_wr_addr = 5'd0; d_tnew = 2'd0;
    step();
    w_we = 1; w_wr_addr = 5'd2; w_wr_data = 32'h1234;
    m_we = 1; m_wr_addr = 5'd7; m_wr_data = 32'h9999;
    #1 chk("imm_src_b", e_src_b, 32'h10);
    chk("imm_store", e_store_data, 32'h1234);
    m_wr_addr = 5'd2;
    #1 chk("imm_store_m", e_store_data, 32'h9999);
    chk("imm_src_b_m", e_src_b, 32'h10);

    m_we = 0; w_we = 0;
    reset = 1; stall = 1; d_pc = 32'h0000_3020;
    step();
    chk("rs_pc", e_pc, 32'h0000_3000);
    chk("rs_mem_we", 32'(e_mem_we), 32'h0);

    reset = 0; stall = 0;
    d_instr = 32'h8C43_0004; d_pc = 32'h0000_3024; d_rs_addr = 5'd2; d_rs_data = 32'h100;
    d_rt_addr = 5'd3; d_rt_data = 32'h200; d_wr_addr = 5'd3; d_alu_src_imm = 1;
    d_ext_imm = 32'h4; d_mem_we = 0; d_mem_to_reg = 1; d_tnew = 2'd2; d_alu_op = ALU_ADD;
    step();
    chk("lw_mem_to_reg", 32'(e_mem_to_reg), 32'd1);
    chk("lw_tnew", 32'(e_tnew), 32'd2);
    w_we = 1; w_wr_addr = 5'd3; w_wr_data = 32'hCAFE;
    step();
    w_we = 0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between decode (D) and execute (E) in the 5-stage MIPS core.
- Captures decoded instruction state on each clock edge.
- Inserts a bubble on a hazard stall.
- Resolves M→E and W→E forwarding and drives the ALU's srcA/srcB operands and aluOp.

Parameters:
- DATA_W, 32, datapath width.
- PC_RESET, 32'h0000_3000, reset value of e_pc.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: load a bubble into E this edge
- d_instr  in  32  D-stage instruction word
- d_pc  in  32  D-stage PC
- d_rs_data  in  DATA_W  GRF[rs] read (already D-forwarded)
- d_rt_data  in  DATA_W  GRF[rt] read (already D-forwarded)
- d_ext_imm  in  DATA_W  extended immediate
- d_rs_addr  in  5  rs index
- d_rt_addr  in  5  rt index
- d_wr_addr  in  5  destination register (0 = none)
- d_alu_op  in  3  ALU operation code (shared ALU op constants)
- d_alu_src_imm  in  1  1: srcB = immediate
- d_mem_we  in  1  store
- d_mem_to_reg  in  1  load
- d_tnew  in  2  cycles until result is available, counted from E
- m_wr_addr  in  5  M-stage destination
- m_wr_data  in  DATA_W  M-stage forwardable result
- m_we  in  1  M-stage result valid for forwarding
- w_wr_addr  in  5  W-stage destination
- w_wr_data  in  DATA_W  W-stage result
- w_we  in  1  W-stage register write
- e_instr, e_pc  out  32  registered copies
- e_rs_addr, e_rt_addr, e_wr_addr  out  5  registered indices
- e_alu_op  out  3  to ALU aluOp
- e_src_a  out  DATA_W  to ALU srcA
- e_src_b  out  DATA_W  to ALU srcB
- e_store_data  out  DATA_W  forwarded rt, to EX/MEM for stores
- e_mem_we, e_mem_to_reg  out  1  registered controls
- e_tnew  out  2  registered Tnew, to hazard unit

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- Edge priority: reset > stall > normal load.
- Reset:
  - e_instr = 0 (sll $0 nop); e_pc = PC_RESET.
  - All addresses, controls, data and e_tnew = 0; e_alu_op = ALU add code.
  - e_src_a and e_src_b therefore read 0 after reset.
- Stall (bubble):
  - All fields load the reset values except e_pc, which loads d_pc. The PC is kept for later exception attribution.
  - A bubble has e_wr_addr = 0 and e_mem_we = 0, so it has no architectural effect.
- Normal load: every e_* register takes its d_* counterpart. Latency is exactly 1 cycle.
- There is no enable other than stall. E never freezes; D/F freezing is outside this block.
- Forwarding (combinational, from registered state):
  - fwd_rs = m_wr_data if m_we && m_wr_addr != 0 && m_wr_addr == e_rs_addr.
  - Else w_wr_data if w_we && w_wr_addr != 0 && w_wr_addr == e_rs_addr.
  - Else the registered rs data. fwd_rt uses the same rule with e_rt_addr.
  - M has priority over W (younger result).
  - Register $0 is never forwarded, even with m_we = 1.
- Outputs: e_src_a = fwd_rs; e_src_b = e_alu_src_imm ? registered ext_imm : fwd_rt; e_store_data = fwd_rt always.
- e_tnew is the registered d_tnew, unchanged. Decrementing happens in EX/MEM.
- Stall and new D data on the same edge: the bubble wins and D data is discarded. The hazard unit holds D, so the data is re-presented next cycle.
- Reset and stall together: reset values load, including e_pc = PC_RESET.
- No combinational path from d_* to e_*. The m_*/w_* → e_src_a/e_src_b/e_store_data path is combinational by design.

Decomposition:
- Shared package/header (existing param include):
  - ALU op codes.
  - NOP instruction constant (32'h0).
  - PC_RESET default.
  - Tnew width.
- Natural sub-module: fwd_mux. One instance per operand; inputs are the index, registered data and the M/W bypass sets; output is the forwarded value. It is instantiated twice, for rs and rt.
- Register bank stays flat in id_ex_reg.

Test Plan:
- Reset:
  - Stimulus: assert reset 1 cycle with d_* nonzero.
  - Response: e_instr = 0, e_pc = 32'h3000, e_wr_addr = 0, e_src_a = e_src_b = 0.
- Normal load:
  - Stimulus: d_instr = 32'h3421_0005 (ori $1,$1,5), d_rs_data = 7, d_ext_imm = 5, d_alu_src_imm = 1, no bypass.
  - Response: next cycle e_src_a = 7, e_src_b = 5, e_wr_addr = 1.
- Bubble:
  - Stimulus: stall = 1 with d_pc = 32'h3010, d_wr_addr = 4, d_mem_we = 1.
  - Response: e_instr = 0, e_wr_addr = 0, e_mem_we = 0, e_pc = 32'h3010.
- Forward priority:
  - Stimulus: e_rs_addr = 3; m_we = 1, m_wr_addr = 3, m_wr_data = 32'hAAAA; w_we = 1, w_wr_addr = 3, w_wr_data = 32'hBBBB.
  - Response: e_src_a = 32'hAAAA. Drop m_we → e_src_a = 32'hBBBB.
- $0 guard:
  - Stimulus: e_rt_addr = 0, d_rt_data was 0, m_we = 1, m_wr_addr = 0, m_wr_data = 32'hFFFF_FFFF.
  - Response: e_store_data = 0, and e_src_b = 0 with alu_src_imm = 0.
- Immediate vs rt:
  - Stimulus: e_rt_addr = 2 bypassed from W with 32'h1234; alu_src_imm = 1, ext_imm = 32'h10.
  - Response: e_src_b = 32'h10, e_store_data = 32'h1234.
